// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bank
// Brief    : Parametrised bidirectional GPIO bank with per-pin direction and
//            output registers, synchronised input sampling and edge-triggered
//            interrupts (rising / falling / both, per pin).
// Revision : 1.0 - initial release
// ============================================================================
// reset_n is expected to be released synchronously to clk by the board-level
// reset generator; assertion is fully asynchronous.
module gpio_bank #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_DDR   = '0,
  parameter logic [WIDTH-1:0] RESET_ODR   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_ODR   = 3'd0;
  localparam logic [2:0] ADDR_DDR   = 3'd1;
  localparam logic [2:0] ADDR_IDR   = 3'd2;
  localparam logic [2:0] ADDR_IER   = 3'd3;
  localparam logic [2:0] ADDR_ISR   = 3'd4;
  localparam logic [2:0] ADDR_IMODE = 3'd5;
  localparam logic [2:0] ADDR_IBOTH = 3'd6;

  localparam int                WARM_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES);

  logic [WIDTH-1:0]  odr_q,   odr_d;
  logic [WIDTH-1:0]  ddr_q,   ddr_d;
  logic [WIDTH-1:0]  ier_q,   ier_d;
  logic [WIDTH-1:0]  isr_q,   isr_d;
  logic [WIDTH-1:0]  imode_q, imode_d;
  logic [WIDTH-1:0]  iboth_q, iboth_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WARM_W-1:0] warm_q,  warm_d;
  logic              warm_done_q;
  logic              irq_q;

  logic [WIDTH-1:0]  idr;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  fall;
  logic [WIDTH-1:0]  hit;
  logic [WIDTH-1:0]  isr_clr;

  assign idr  = sync_q[SYNC_STAGES-1];
  assign rise = idr & ~prev_q;
  assign fall = ~idr & prev_q;

  // Edge selection per pin; suppressed until the sync chain and prev sample
  // both hold real pad levels, so reset-time levels never look like edges.
  always_comb begin
    hit = '0;
    if (warm_done_q) begin
      hit = (iboth_q & (rise | fall))
          | (~iboth_q &  imode_q & fall)
          | (~iboth_q & ~imode_q & rise);
    end
  end

  // Next-state for the register file, warm-up counter and read data.
  always_comb begin
    odr_d   = odr_q;
    ddr_d   = ddr_q;
    ier_d   = ier_q;
    imode_d = imode_q;
    iboth_d = iboth_q;
    rdata_d = rdata_q;
    isr_clr = '0;
    warm_d  = (warm_q == WARM_MAX) ? warm_q : warm_q + WARM_W'(1);
    if (write) begin
      case (addr)
        ADDR_ODR:   odr_d   = wdata;
        ADDR_DDR:   ddr_d   = wdata;
        ADDR_IER:   ier_d   = wdata;
        ADDR_ISR:   isr_clr = wdata;
        ADDR_IMODE: imode_d = wdata;
        ADDR_IBOTH: iboth_d = wdata;
        default:    ;
      endcase
    end
    // A set from a new edge wins over a same-cycle write-1-to-clear.
    isr_d = (isr_q & ~isr_clr) | hit;
    if (read) begin
      case (addr)
        ADDR_ODR:   rdata_d = odr_q;
        ADDR_DDR:   rdata_d = ddr_q;
        ADDR_IDR:   rdata_d = idr;
        ADDR_IER:   rdata_d = ier_q;
        ADDR_ISR:   rdata_d = isr_q;
        ADDR_IMODE: rdata_d = imode_q;
        ADDR_IBOTH: rdata_d = iboth_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Register file, interrupt state and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      odr_q       <= RESET_ODR;
      ddr_q       <= RESET_DDR;
      ier_q       <= '0;
      isr_q       <= '0;
      imode_q     <= '0;
      iboth_q     <= '0;
      rdata_q     <= '0;
      warm_q      <= '0;
      warm_done_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      odr_q       <= odr_d;
      ddr_q       <= ddr_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      imode_q     <= imode_d;
      iboth_q     <= iboth_d;
      rdata_q     <= rdata_d;
      warm_q      <= warm_d;
      // One extra cycle after saturation lets prev catch up with IDR.
      warm_done_q <= (warm_q == WARM_MAX);
      irq_q       <= |(isr_q & ier_q);
    end
  end

  // Input synchroniser chain and previous-sample register for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= idr;
    end
  end

  assign rdata    = rdata_q;
  assign pins_out = odr_q;
  assign pins_oe  = ddr_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire
